// File: rtl/ipu_window_scanner.sv
// ipu_window_scanner
// Sweeps a grayscale frame in raster order, gathers a zero-padded 5x5 window
// around each pixel from image memory, hands it to the convolution coprocessor
// through its external operand path, and writes the 8-bit saturated result to
// output memory.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    frame start pulse (only honoured while idle)
//   instruction, kernel_in   coprocessor instruction and 5x5 kernel, latched at start
//   busy, done_frame         frame in progress / one-cycle end-of-frame pulse
//   mem_rd_en/addr/data      image memory read port (data valid 1 cycle after en)
//   ipu_request              selects external operands inside the coprocessor
//   matrix_A, matrix_B       current window / latched kernel
//   cop_instruction          latched instruction
//   cop_activate             one-cycle instruction issue pulse
//   cop_wait, cop_done       coprocessor busy / operation complete
//   cop_result               coprocessor result
//   wr_en/addr/data          output memory write port
module ipu_window_scanner #(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       instruction,
  input  logic [199:0]      kernel_in,
  output logic              busy,
  output logic              done_frame,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              ipu_request,
  output logic [199:0]      matrix_A,
  output logic [199:0]      matrix_B,
  output logic [31:0]       cop_instruction,
  output logic              cop_activate,
  input  logic              cop_wait,
  input  logic              cop_done,
  input  logic [31:0]       cop_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  typedef enum logic [2:0] {
    StIdle,
    StGather,
    StIssue,
    StWait,
    StWrite,
    StFinish
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] x_q, y_q;
  logic [4:0]        gk_q;      // gather cycle index, 0..25
  logic              rd_pend_q; // read issued last cycle; data arrives now

  // Next pixel in raster order.
  logic              last_col, last_px;
  logic [ADDR_W-1:0] nx, ny;
  logic [ADDR_W-1:0] pix_addr;

  // Look-ahead element: the one whose read strobe is registered at this edge.
  logic [ADDR_W-1:0] la_x, la_y;
  logic [4:0]        la_k;
  int                la_r, la_c, la_px, la_py;
  logic              la_inb;
  logic [ADDR_W-1:0] la_addr;

  logic [7:0]        sat_data;
  logic [4:0]        wk;

  // Bits above the 16-bit saturation field are not needed.
  logic              unused_result;
  assign unused_result = ^cop_result[31:16];

  always_comb begin
    last_col = (x_q == ADDR_W'(IMG_W - 1));
    last_px  = last_col && (y_q == ADDR_W'(IMG_H - 1));
    nx       = last_col ? '0 : x_q + 1'b1;
    ny       = last_col ? y_q + 1'b1 : y_q;
    pix_addr = ADDR_W'(int'(y_q) * IMG_W + int'(x_q));

    la_x = x_q;
    la_y = y_q;
    la_k = gk_q + 5'd1;
    if (state_q == StIdle) begin
      la_x = '0;
      la_y = '0;
      la_k = '0;
    end else if (state_q == StWrite) begin
      la_x = nx;
      la_y = ny;
      la_k = '0;
    end

    // Signed coordinates so that x-2 / y-2 never alias a valid address.
    la_r    = int'(la_k) / 5;
    la_c    = int'(la_k) % 5;
    la_px   = int'(la_x) + la_c - 2;
    la_py   = int'(la_y) + la_r - 2;
    la_inb  = (la_px >= 0) && (la_px < IMG_W) && (la_py >= 0) && (la_py < IMG_H);
    la_addr = ADDR_W'(la_py * IMG_W + la_px);

    sat_data = (cop_result[15:8] != 8'd0) ? 8'hFF : cop_result[7:0];
    wk       = gk_q - 5'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      x_q             <= '0;
      y_q             <= '0;
      gk_q            <= '0;
      rd_pend_q       <= 1'b0;
      busy            <= 1'b0;
      done_frame      <= 1'b0;
      mem_rd_en       <= 1'b0;
      mem_rd_addr     <= '0;
      ipu_request     <= 1'b0;
      matrix_A        <= '0;
      matrix_B        <= '0;
      cop_instruction <= '0;
      cop_activate    <= 1'b0;
      wr_en           <= 1'b0;
      wr_addr         <= '0;
      wr_data         <= '0;
    end else begin
      cop_activate <= 1'b0;
      wr_en        <= 1'b0;
      done_frame   <= 1'b0;
      mem_rd_en    <= 1'b0;
      mem_rd_addr  <= '0;
      rd_pend_q    <= mem_rd_en;

      case (state_q)
        StIdle: begin
          if (start) begin
            cop_instruction <= instruction;
            matrix_B        <= kernel_in;
            x_q             <= '0;
            y_q             <= '0;
            gk_q            <= '0;
            busy            <= 1'b1;
            mem_rd_en       <= la_inb;
            mem_rd_addr     <= la_inb ? la_addr : '0;
            state_q         <= StGather;
          end
        end

        StGather: begin
          // Element gk-1 completes now: its read data (or padding zero) lands.
          if (gk_q != 5'd0) begin
            matrix_A[{wk, 3'b000} +: 8] <= rd_pend_q ? mem_rd_data : 8'd0;
          end
          if (gk_q == 5'd25) begin
            ipu_request <= 1'b1;
            state_q     <= StIssue;
          end else begin
            gk_q <= gk_q + 5'd1;
            if (gk_q != 5'd24) begin
              mem_rd_en   <= la_inb;
              mem_rd_addr <= la_inb ? la_addr : '0;
            end
          end
        end

        StIssue: begin
          if (!cop_wait) begin
            cop_activate <= 1'b1;
            state_q      <= StWait;
          end
        end

        StWait: begin
          // A done coinciding with the issue pulse belongs to an older operation.
          if (cop_done && !cop_activate) begin
            wr_en       <= 1'b1;
            wr_addr     <= pix_addr;
            wr_data     <= sat_data;
            ipu_request <= 1'b0;
            state_q     <= StWrite;
          end
        end

        StWrite: begin
          if (last_px) begin
            x_q        <= '0;
            y_q        <= '0;
            busy       <= 1'b0;
            done_frame <= 1'b1;
            state_q    <= StFinish;
          end else begin
            x_q         <= nx;
            y_q         <= ny;
            gk_q        <= '0;
            mem_rd_en   <= la_inb;
            mem_rd_addr <= la_inb ? la_addr : '0;
            state_q     <= StGather;
          end
        end

        StFinish: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ipu_window_scanner.sv
module tb_ipu_window_scanner;
  localparam int IW   = 8;
  localparam int IH   = 6;
  localparam int AW   = 6;
  localparam int NPIX = IW * IH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   instruction = '0;
  logic [199:0]  kernel_in = '0;
  logic          busy, done_frame, mem_rd_en, ipu_request, cop_activate, wr_en;
  logic [AW-1:0] mem_rd_addr, wr_addr;
  logic [7:0]    mem_rd_data = '0;
  logic [7:0]    wr_data;
  logic [199:0]  matrix_A, matrix_B;
  logic [31:0]   cop_instruction;
  logic          cop_wait;
  logic          cop_done = 1'b0;
  logic [31:0]   cop_result = '0;

  int total = 0;
  int bad   = 0;

  logic [7:0]    img_mem [64];
  logic [7:0]    out_mem [64];
  logic [AW-1:0] wr_log_addr [1024];
  logic [7:0]    wr_log_data [1024];
  int rd_count = 0, wr_count = 0, done_count = 0, act_count = 0;

  logic          wait_force = 1'b0;
  logic          ovr_en = 1'b0;
  logic [31:0]   ovr_val = '0;
  int            cop_cnt = 0;

  assign cop_wait = wait_force;

  ipu_window_scanner #(.IMG_W(IW), .IMG_H(IH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .instruction(instruction), .kernel_in(kernel_in),
    .busy(busy), .done_frame(done_frame), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .ipu_request(ipu_request), .matrix_A(matrix_A),
    .matrix_B(matrix_B), .cop_instruction(cop_instruction), .cop_activate(cop_activate),
    .cop_wait(cop_wait), .cop_done(cop_done), .cop_result(cop_result), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // Memories and event counters.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= img_mem[mem_rd_addr];
      rd_count    <= rd_count + 1;
    end
    if (wr_en) begin
      out_mem[wr_addr]            <= wr_data;
      wr_log_addr[wr_count % 1024] <= wr_addr;
      wr_log_data[wr_count % 1024] <= wr_data;
      wr_count                    <= wr_count + 1;
    end
    if (done_frame) done_count <= done_count + 1;
    if (cop_activate) act_count <= act_count + 1;
  end

  // Coprocessor: returns the window centre (or an override) 3 cycles after issue.
  always @(posedge clk) begin
    if (rst) begin
      cop_cnt  <= 0;
      cop_done <= 1'b0;
    end else begin
      cop_done <= 1'b0;
      if (cop_activate) cop_cnt <= 3;
      else if (cop_cnt != 0) begin
        cop_cnt <= cop_cnt - 1;
        if (cop_cnt == 1) begin
          cop_done   <= 1'b1;
          cop_result <= ovr_en ? ovr_val : {24'd0, matrix_A[103:96]};
        end
      end
    end
  end

  task automatic pulse_start(input logic [31:0] ins, input logic [199:0] k);
    @(negedge clk);
    instruction = ins;
    kernel_in   = k;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    int base;
    base = done_count;
    ok   = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done_count != base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done_frame, mem_rd_en, mem_rd_addr, ipu_request, cop_activate, wr_en, wr_addr,
         wr_data, cop_instruction} !== '0) begin
      bad++;
      $display("FAIL reset_scalars: got busy=%b done=%b rd=%b ipu=%b act=%b wr=%b ins=%h want 0",
               busy, done_frame, mem_rd_en, ipu_request, cop_activate, wr_en, cop_instruction);
    end
    total++;
    if ({matrix_A, matrix_B} !== '0) begin
      bad++;
      $display("FAIL reset_matrices: got A=%h B=%h want 0", matrix_A, matrix_B);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, mem_rd_en, wr_en} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle: got busy=%b rd=%b wr=%b want 0", busy, mem_rd_en, wr_en);
    end
  endtask

  task automatic test_full_frame;
    logic [199:0] k;
    int base_w, base_d, nbad, first_bad;
    bit ok;
    for (int i = 0; i < 64; i++) img_mem[i] = 8'(i);
    for (int i = 0; i < 25; i++) k[8*i +: 8] = 8'(i * 7 + 1);
    base_w = wr_count;
    base_d = done_count;
    pulse_start(32'hA5A5_0001, k);
    total++;
    if (busy !== 1'b1 || matrix_B !== k || cop_instruction !== 32'hA5A5_0001) begin
      bad++;
      $display("FAIL frame_latch: got busy=%b ins=%h B=%h want 1 a5a50001 %h",
               busy, cop_instruction, matrix_B, k);
    end
    wait_done(4000, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL frame_timeout: got no done_frame want done within 4000 cycles");
    end
    total++;
    if (wr_count - base_w != NPIX) begin
      bad++;
      $display("FAIL frame_writes: got %0d want %0d", wr_count - base_w, NPIX);
    end
    total++;
    if (done_count - base_d != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL frame_done: got dones=%0d busy=%b want 1 0", done_count - base_d, busy);
    end
    nbad = 0;
    first_bad = -1;
    for (int i = 0; i < NPIX; i++) begin
      if (out_mem[i] !== 8'(i)) begin
        nbad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    total++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL frame_data: got %0d wrong, first at %0d = %h, want out[i]=i",
               nbad, first_bad, out_mem[first_bad]);
    end
  endtask

  task automatic test_corner_window;
    logic [199:0] k, expw;
    int base_r, cyc;
    bit ok;
    for (int i = 0; i < 64; i++) img_mem[i] = 8'(i + 1);
    k = {25{8'h02}};
    expw = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if (r >= 2 && c >= 2) expw[8*(5*r+c) +: 8] = 8'((r - 2) * IW + (c - 2) + 1);
    base_r = rd_count;
    pulse_start(32'h0000_0002, k);
    cyc = 0;
    while (ipu_request !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (ipu_request !== 1'b1) begin
      bad++;
      $display("FAIL corner_issue: got ipu_request=%b want 1 within 100 cycles", ipu_request);
    end
    total++;
    if (rd_count - base_r != 9) begin
      bad++;
      $display("FAIL corner_reads: got %0d want 9", rd_count - base_r);
    end
    total++;
    if (matrix_A[79:0] !== 80'd0 || matrix_A[8*5 +: 16] !== 16'd0 ||
        matrix_A[8*20 +: 16] !== 16'd0) begin
      bad++;
      $display("FAIL corner_padding: got A=%h want rows 0-1, cols 0-1 zero", matrix_A);
    end
    total++;
    if (matrix_A[103:96] !== 8'd1 || matrix_A[111:104] !== 8'd2 ||
        matrix_A[143:136] !== 8'd9) begin
      bad++;
      $display("FAIL corner_elems: got (2,2)=%0d (2,3)=%0d (3,2)=%0d want 1 2 9",
               matrix_A[103:96], matrix_A[111:104], matrix_A[143:136]);
    end
    total++;
    if (matrix_A !== expw) begin
      bad++;
      $display("FAIL corner_window: got %h want %h", matrix_A, expw);
    end
    wait_done(4000, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL corner_timeout: got no done_frame want done within 4000 cycles");
    end
  endtask

  task automatic test_saturation;
    int base, cyc;
    bit ok;
    ovr_en  = 1'b1;
    ovr_val = 32'h0000_012C;
    base = wr_count;
    pulse_start(32'h0000_0003, {25{8'h01}});
    cyc = 0;
    while (wr_count < base + 1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    ovr_val = 32'h0000_007F;
    total++;
    if (wr_count < base + 1 || wr_log_data[base % 1024] !== 8'd255 ||
        wr_log_addr[base % 1024] !== 6'd0) begin
      bad++;
      $display("FAIL sat_12c: got data=%0d addr=%0d want 255 0",
               wr_log_data[base % 1024], wr_log_addr[base % 1024]);
    end
    cyc = 0;
    while (wr_count < base + 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    ovr_val = 32'hFFFF_0042;
    total++;
    if (wr_count < base + 2 || wr_log_data[(base + 1) % 1024] !== 8'd127 ||
        wr_log_addr[(base + 1) % 1024] !== 6'd1) begin
      bad++;
      $display("FAIL sat_7f: got data=%0d addr=%0d want 127 1",
               wr_log_data[(base + 1) % 1024], wr_log_addr[(base + 1) % 1024]);
    end
    cyc = 0;
    while (wr_count < base + 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (wr_count < base + 3 || wr_log_data[(base + 2) % 1024] !== 8'h42) begin
      bad++;
      $display("FAIL sat_high_bits: got data=%h want 42", wr_log_data[(base + 2) % 1024]);
    end
    ovr_en = 1'b0;
    wait_done(4000, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL sat_timeout: got no done_frame want done within 4000 cycles");
    end
  endtask

  task automatic test_cop_wait;
    int base_a, cyc;
    bit ok, ipu_drop;
    wait_force = 1'b1;
    base_a = act_count;
    pulse_start(32'h0000_0004, {25{8'h03}});
    cyc = 0;
    while (ipu_request !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    ipu_drop = (ipu_request !== 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ipu_request !== 1'b1) ipu_drop = 1'b1;
    end
    total++;
    if (act_count != base_a || cop_activate !== 1'b0) begin
      bad++;
      $display("FAIL wait_no_issue: got %0d pulses want 0 while cop_wait high",
               act_count - base_a);
    end
    wait_force = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ipu_request !== 1'b1) ipu_drop = 1'b1;
    end
    total++;
    if (act_count - base_a != 1) begin
      bad++;
      $display("FAIL wait_single_issue: got %0d pulses want 1", act_count - base_a);
    end
    total++;
    if (ipu_drop) begin
      bad++;
      $display("FAIL wait_ipu_request: got a low ipu_request want 1 throughout");
    end
    wait_done(4000, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_timeout: got no done_frame want done within 4000 cycles");
    end
  endtask

  task automatic test_reset_mid_frame;
    int base, base2, cyc;
    bit ok;
    base = wr_count;
    pulse_start(32'h0000_0005, {25{8'h04}});
    cyc = 0;
    while (wr_count < base + 20 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    cyc = 0;
    while (cop_activate !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cop_activate !== 1'b1 || wr_count - base != 20) begin
      bad++;
      $display("FAIL rstmid_reach: got act=%b writes=%0d want 1 20", cop_activate,
               wr_count - base);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done_frame, mem_rd_en, mem_rd_addr, ipu_request, cop_activate, wr_en, wr_addr,
         wr_data, cop_instruction, matrix_A, matrix_B} !== '0) begin
      bad++;
      $display("FAIL rstmid_outputs: got busy=%b ipu=%b act=%b wr=%b A=%h want all 0",
               busy, ipu_request, cop_activate, wr_en, matrix_A);
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (busy !== 1'b0 || wr_count - base != 20) begin
      bad++;
      $display("FAIL rstmid_idle: got busy=%b writes=%0d want 0 20", busy, wr_count - base);
    end
    base2 = wr_count;
    pulse_start(32'h0000_0006, {25{8'h05}});
    wait_done(4000, ok);
    total++;
    if (!ok || wr_count - base2 != NPIX || wr_log_addr[base2 % 1024] !== 6'd0) begin
      bad++;
      $display("FAIL rstmid_restart: got done=%b writes=%0d first_addr=%0d want 1 %0d 0",
               ok, wr_count - base2, wr_log_addr[base2 % 1024], NPIX);
    end
  endtask

  task automatic test_start_ignored;
    logic [199:0] ka, kb;
    int base, base_d, cyc;
    bit ok;
    for (int i = 0; i < 25; i++) begin
      ka[8*i +: 8] = 8'(i + 40);
      kb[8*i +: 8] = 8'(200 - i);
    end
    base   = wr_count;
    base_d = done_count;
    pulse_start(32'hCAFE_0007, ka);
    instruction = 32'hDEAD_BEEF;
    kernel_in   = kb;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (wr_en !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (matrix_B !== ka || cop_instruction !== 32'hCAFE_0007 || busy !== 1'b1) begin
      bad++;
      $display("FAIL ignore_latch: got ins=%h busy=%b B=%h want cafe0007 1 %h",
               cop_instruction, busy, matrix_B, ka);
    end
    wait_done(4000, ok);
    repeat (5) @(negedge clk);
    total++;
    if (!ok || wr_count - base != NPIX || done_count - base_d != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_frame: got done=%b writes=%0d dones=%0d busy=%b want 1 %0d 1 0",
               ok, wr_count - base, done_count - base_d, busy, NPIX);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      img_mem[i] = '0;
      out_mem[i] = '0;
    end
    test_reset();
    test_full_frame();
    test_corner_window();
    test_saturation();
    test_cop_wait();
    test_reset_mid_frame();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ipu_window_scanner.md
Name: ipu_window_scanner

Overview:
Image processing unit (IPU) front end that feeds the convolution coprocessor. It sweeps a grayscale frame in raster order and gathers a 5x5 zero-padded window around each pixel from image memory. For each window it drives the coprocessor's external operand path with ipu_request, issues the held instruction, and collects the result. Each result is saturated to 8 bits and written to output memory.

Parameters:
IMG_W, 160, frame width in pixels
IMG_H, 120, frame height in pixels
ADDR_W, 15, pixel address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  frame start pulse; sampled in IDLE only
instruction  in  32  coprocessor instruction; latched at start
kernel_in  in  200  5x5 kernel, 8 bits per element; latched at start
busy  out  1  high from the start-accept cycle until done_frame
done_frame  out  1  one-cycle pulse after the last pixel write
mem_rd_en  out  1  image memory read strobe
mem_rd_addr  out  ADDR_W  read address, y*IMG_W+x
mem_rd_data  in  8  read data, valid exactly 1 cycle after mem_rd_en
ipu_request  out  1  selects external operands inside the coprocessor
matrix_A  out  200  current window
matrix_B  out  200  latched kernel
cop_instruction  out  32  latched instruction
cop_activate  out  1  one-cycle instruction issue pulse
cop_wait  in  1  coprocessor busy (not in FETCH)
cop_done  in  1  coprocessor operation complete
cop_result  in  32  coprocessor matrix_C output
wr_en  out  1  output memory write strobe, one cycle
wr_addr  out  ADDR_W  output address, y*IMG_W+x
wr_data  out  8  saturated result

Behaviour:
- Reset values: all outputs 0; state IDLE; x=y=0; window, kernel and instruction registers cleared. rst mid-frame aborts immediately and leaves no pending strobe on the next cycle.
- Window layout: element (r,c), r,c in 0..4, occupies bits [8*(5r+c)+7 : 8*(5r+c)]. The centre (2,2) is pixel (x,y). Element maps to image coordinate (x+c-2, y+r-2).
- States: IDLE, GATHER, ISSUE, WAIT, WRITE, FINISH.
- IDLE: when start=1, latch instruction and kernel_in, clear x=y=0, set busy=1, go to GATHER. Any start outside IDLE is ignored.
- GATHER:
  - Index k steps 0..24, one per cycle.
  - In-bounds element: mem_rd_en=1 with its address.
  - Out-of-bounds element: mem_rd_en=0 and a 0 is stored for that element.
  - Captured data is written into element k one cycle later.
  - Exactly 26 cycles in GATHER, then go to ISSUE.
- ISSUE: ipu_request=1.
  - If cop_wait=0: cop_activate=1 for exactly one cycle, then go to WAIT.
  - If cop_wait=1: stay in ISSUE without pulsing.
- WAIT: ipu_request held at 1, and matrix_A/matrix_B held stable.
  - On cop_done=1, capture cop_result and go to WRITE.
  - cop_done high in the same cycle as the ISSUE pulse is ignored.
- WRITE:
  - wr_en=1 for one cycle with wr_addr=y*IMG_W+x.
  - wr_data = 255 if cop_result[15:8]!=0, else cop_result[7:0].
  - ipu_request drops to 0.
  - Advance x. At x=IMG_W-1, wrap x to 0 and increment y.
  - If this was the pixel (IMG_W-1, IMG_H-1), go to FINISH; else go to GATHER.
- FINISH: done_frame=1 for one cycle, busy=0, go to IDLE.
- Latency per pixel: 26 (GATHER) + 1 (ISSUE, if cop_wait=0) + coprocessor latency + 1 (WRITE).
- Address arithmetic is computed in ADDR_W bits. Out-of-bounds tests use signed coordinates, so x-2 and y-2 must never wrap into a valid address.

Test Plan:
1. IMG_W=8, IMG_H=6; memory[i]=i; coprocessor model returns the centre element after 3 cycles -> output memory equals input (addresses 0..47); exactly 48 wr_en pulses; one done_frame; busy low afterwards.
2. Pixel (0,0) window, memory[i]=i+1 -> rows 0-1 and columns 0-1 of matrix_A are 0; element (2,2)=1, (2,3)=2, (3,2)=9; exactly 9 mem_rd_en pulses in that GATHER.
3. cop_result=0x0000_012C -> wr_data=255; cop_result=0x0000_007F -> wr_data=127.
4. cop_wait held high for 10 cycles on entering ISSUE -> no cop_activate until cop_wait falls; then a single pulse; ipu_request high throughout.
5. Assert rst during WAIT of pixel 20 -> next cycle all outputs 0; state IDLE; a new start restarts at (0,0) with wr_addr=0 first.
6. start pulsed while busy, and at the same cycle as a write -> ignored; latched instruction and kernel unchanged; frame completes normally.
